// File: rtl/alu_muldiv_seq_pkg.sv
// Shared CPU definitions used by the sequential multiply/divide unit.
// Op encodings and ALU function codes.
package alu_muldiv_seq_pkg;

  localparam int XLEN_C = 64;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSVD = 2'b11
  } md_op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle of the sequential multiply/divide unit.
// The master issues requests; the unit is the slave.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 64
);

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, opa, opb,
    input  busy, done, result
  );

  modport slave (
    input  start, op, opa, opb,
    output busy, done, result
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MUL/DIVU/REMU unit, one shared-ALU operation per cycle.
// Shift-add multiply and restoring division over 64 iterations.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave bus,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_func,
  output logic            alu_sub_sra,
  input  logic [XLEN-1:0] alu_s,
  input  logic            alu_lu
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e          state_q;
  md_op_e          op_q;
  md_op_e          op_in;
  logic [XLEN-1:0] a_q, b_q, c_q;
  logic [XLEN-1:0] a_d, c_d;
  logic [XLEN-1:0] cand, res_d;
  logic [6:0]      cnt_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;
  logic            run, is_mul;
  logic            rsvd, dz;

  // a: acc / rem, b: mcand / divisor, c: mplier / quo
  assign run    = (state_q == S_RUN);
  assign is_mul = (op_q == OP_MUL);
  assign cand   = {a_q[XLEN-2:0], c_q[XLEN-1]};

  assign alu_a       = run ? (is_mul ? a_q : cand) : '0;
  assign alu_b       = run ? b_q : '0;
  assign alu_sub_sra = run && !is_mul;
  assign alu_func    = ALU_ADD;

  assign op_in = md_op_e'(bus.op);
  assign rsvd  = (op_in == OP_RSVD);
  assign dz    = (op_in == OP_DIVU || op_in == OP_REMU)
              && (bus.opb == '0);

  always_comb begin
    a_d = a_q;
    c_d = c_q;
    if (is_mul) begin
      if (c_q[0]) a_d = alu_s;
      c_d = c_q >> 1;
    end else if (a_q[XLEN-1] || !alu_lu) begin
      a_d = alu_s;
      c_d = {c_q[XLEN-2:0], 1'b1};
    end else begin
      a_d = cand;
      c_d = {c_q[XLEN-2:0], 1'b0};
    end
  end

  assign res_d = (op_q == OP_DIVU) ? c_d : a_d;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q   <= op_in;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            a_q    <= '0;
            b_q    <= (op_in == OP_MUL) ? bus.opa : bus.opb;
            c_q    <= (op_in == OP_MUL) ? bus.opb : bus.opa;
            unique case (1'b1)
              rsvd: begin
                state_q  <= S_FIN;
                done_q   <= 1'b1;
                result_q <= '0;
              end
              dz: begin
                state_q  <= S_FIN;
                done_q   <= 1'b1;
                result_q <= (op_in == OP_DIVU) ? '1 : bus.opa;
              end
              default: state_q <= S_RUN;
            endcase
          end
        end
        S_RUN: begin
          a_q   <= a_d;
          b_q   <= is_mul ? (b_q << 1) : b_q;
          c_q   <= c_d;
          cnt_q <= cnt_q + 7'd1;
          if (cnt_q == 7'd63) begin
            state_q  <= S_FIN;
            done_q   <= 1'b1;
            result_q <= res_d;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 Parameter: XLEN, default 64, operand/result width; only 64 is supported.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request strobe; sampled only when busy=0.
REQ-005 op  in  2  00=MUL (low 64 bits), 01=DIVU, 10=REMU, 11=reserved.
REQ-006 opa, opb  in  64  operand A (multiplicand/dividend) and operand B (multiplier/divisor), sampled with start.
REQ-007 busy  out  1  high from the cycle after acceptance until the cycle done is high, inclusive.
REQ-008 done  out  1  one-cycle pulse; result valid while done=1.
REQ-009 result  out  64  product, quotient or remainder; holds its value until the next acceptance.
REQ-010 alu_a, alu_b  out  64  operands driven to the shared ALU.
REQ-011 alu_func  out  3  ALU function select; always 000 (add).
REQ-012 alu_sub_sra  out  1  ALU subtract enable.
REQ-013 alu_s  in  64  ALU sum/difference output.
REQ-014 alu_lu  in  1  ALU unsigned less-than flag (a<b); valid only when alu_sub_sra=1.

Function
REQ-015 FSM states are IDLE, RUN and FIN; the encoding is local to the block.
REQ-016 IDLE: when start=1 the block SHALL latch op/opa/opb, clear the 7-bit iteration counter, and move to RUN (or to FIN per REQ-022/REQ-023).
REQ-017 RUN SHALL take exactly 64 cycles, one ALU operation per cycle, then move to FIN.
REQ-018 FIN SHALL last one cycle with done=1, load result and return to IDLE; start is ignored in FIN.
REQ-019 Latency: start accepted at edge N produces done=1 in the cycle after edge N+64 (65 cycles from acceptance); start is ignored whenever busy=1.
REQ-020 MUL iteration: alu_a=acc, alu_b=mcand, alu_sub_sra=0; if mplier[0]=1 then acc<=alu_s; always mcand<=mcand<<1 and mplier<=mplier>>1; overflow beyond bit 63 is discarded.
REQ-021 DIVU/REMU iteration (restoring): cand={rem[62:0],quo[63]}, alu_a=cand, alu_b=divisor, alu_sub_sra=1. If rem[63]=1 or alu_lu=0, then rem<=alu_s and quo<={quo[62:0],1}; otherwise rem<=cand and quo<={quo[62:0],0}. Initial state: quo=dividend, rem=0.
REQ-022 Divisor zero (op 01/10, opb=0): skip RUN and go directly to FIN; DIVU result=64'hFFFF_FFFF_FFFF_FFFF, REMU result=opa.
REQ-023 op=11: skip RUN; FIN result=0.
REQ-024 In IDLE and FIN, alu_a=0, alu_b=0 and alu_sub_sra=0.
REQ-025 All outputs SHALL be driven from registers or state decode; there is no combinational path from start to any ALU output.

Reset
REQ-026 While rst_n=0: state=IDLE, busy=0, done=0, result=0, and all internal registers=0.
REQ-027 Asserting reset mid-operation SHALL abort the operation with no done pulse; after release the block accepts a new start in the first IDLE cycle.

Structure
REQ-028 The ALU func codes (add=000) and the op encodings SHALL live in the shared CPU package; the FSM state encoding stays local.
REQ-029 The block has no sub-modules; the ALU is instantiated externally and shared through the mux owned by the datapath.

Verification
REQ-030 MUL 7x6: done at cycle 65 with result=42; busy high for 65 cycles.
REQ-031 MUL 0xFFFF_FFFF_FFFF_FFFF x 2 -> result=0xFFFF_FFFF_FFFF_FFFE (wrap).
REQ-032 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x8000_0000_0000_0000/3 -> 0x2AAA_AAAA_AAAA_AAAA (exercises the rem[63] path).
REQ-033 DIVU 5/0 -> done in the cycle after acceptance with result=all ones; REMU 5/0 -> 5.
REQ-034 A start pulse at cycle 10 of a running MUL is ignored, and the original result is returned unchanged.
REQ-035 rst_n low at cycle 30 of a DIVU -> no done pulse, result=0, busy=0; a new MUL 3x3 after release returns 9.
